// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: data-memory req/ack sequencing, pipeline stall,
// branch resolution and the MEM/WB pipeline register.
//
// state | meaning
// IDLE  | no access outstanding; new load/store accepted when !hlt
// WAIT  | dmem_req held, waiting for dmem_ack or timeout
// RESP  | access finished; WB register loads on the closing edge
module mem_stage_ctrl #(
    parameter int ACK_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hlt,
    input  logic        re,
    input  logic        we,
    input  logic [21:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] alu_result,
    input  logic        use_dst_reg,
    input  logic [4:0]  dst_reg,
    input  logic        is_branch,
    input  logic [2:0]  branch_cond,
    input  logic        flag_ov,
    input  logic        flag_neg,
    input  logic        flag_zero,
    input  logic [21:0] pc_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [21:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        branch_taken,
    output logic [21:0] branch_pc,
    output logic        wb_we,
    output logic [4:0]  wb_dst_reg,
    output logic [31:0] wb_data,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      load_buf;
    logic             start;
    logic             timeout;
    logic             stall_core;
    logic             wb_upd;
    logic             cond_met;

    assign start   = (re | we) & ~hlt;
    // Terminal count reached on the last permitted WAIT cycle.
    assign timeout = (wait_cnt == CNT_TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (dmem_ack || timeout) state_nxt = RESP;
            // Holding RESP under hlt keeps the finished access until WB can take it.
            RESP:    if (!hlt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cond_met = 1'b0;
        case (branch_cond)
            3'b000:  cond_met = ~flag_zero;
            3'b001:  cond_met = flag_zero;
            3'b010:  cond_met = ~flag_zero & ~flag_neg;
            3'b011:  cond_met = flag_neg;
            3'b100:  cond_met = ~flag_neg;
            3'b101:  cond_met = flag_neg | flag_zero;
            3'b110:  cond_met = flag_ov;
            default: cond_met = 1'b1;
        endcase
    end

    always_comb begin
        stall_core   = ((state == IDLE) && start) || (state == WAIT);
        stall        = rst_n & stall_core;
        branch_taken = rst_n & (state == IDLE) & is_branch & ~hlt & ~(re | we) & cond_met;
        branch_pc    = rst_n ? pc_target : 22'd0;
        wb_upd       = ~hlt & ~stall_core;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            wait_cnt   <= '0;
            load_buf   <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= we;
                        dmem_addr  <= addr;
                        dmem_wdata <= wdata;
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        load_buf <= dmem_rdata;
                    end else if (timeout) begin
                        dmem_req <= 1'b0;
                        load_buf <= '0;
                        mem_err  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we      <= 1'b0;
            wb_dst_reg <= '0;
            wb_data    <= '0;
        end else if (wb_upd) begin
            wb_we      <= use_dst_reg;
            wb_dst_reg <= dst_reg;
            wb_data    <= re ? load_buf : alu_result;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected memory requests and
// writebacks are queued by the stimulus and checked by a monitor.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hlt, re, we, use_dst_reg, is_branch;
    logic        flag_ov, flag_neg, flag_zero, dmem_ack;
    logic [21:0] addr, pc_target, dmem_addr, branch_pc;
    logic [31:0] wdata, alu_result, dmem_rdata, dmem_wdata, wb_data;
    logic [4:0]  dst_reg, wb_dst_reg;
    logic [2:0]  branch_cond;
    logic        dmem_req, dmem_we, stall, branch_taken, wb_we, mem_err;

    mem_stage_ctrl #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .hlt(hlt), .re(re), .we(we), .addr(addr),
        .wdata(wdata), .alu_result(alu_result), .use_dst_reg(use_dst_reg),
        .dst_reg(dst_reg), .is_branch(is_branch), .branch_cond(branch_cond),
        .flag_ov(flag_ov), .flag_neg(flag_neg), .flag_zero(flag_zero),
        .pc_target(pc_target), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .branch_taken(branch_taken),
        .branch_pc(branch_pc), .wb_we(wb_we), .wb_dst_reg(wb_dst_reg),
        .wb_data(wb_data), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic w; logic [21:0] a; logic [31:0] d; } mem_exp_t;
    typedef struct { logic [4:0] r; logic [31:0] d; } wb_exp_t;

    mem_exp_t mem_q[$];
    wb_exp_t  wb_q[$];
    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: a rising dmem_req presents a request, a rising wb_we a writeback.
    initial begin : monitor
        mem_exp_t cur;
        wb_exp_t  wexp;
        logic     prev_req, prev_wb;
        prev_req = 1'b0;
        prev_wb  = 1'b0;
        cur      = '{w: 1'b0, a: 22'd0, d: 32'd0};
        forever begin
            @(negedge clk);
            if (dmem_req && !prev_req) begin
                if (mem_q.size() == 0) chk("mem_unexpected_req", 32'd1, 32'd0);
                else cur = mem_q.pop_front();
            end
            if (dmem_req) begin
                chk("dmem_we", {31'd0, dmem_we}, {31'd0, cur.w});
                chk("dmem_addr", {10'd0, dmem_addr}, {10'd0, cur.a});
                chk("dmem_wdata", dmem_wdata, cur.d);
            end
            if (wb_we && !prev_wb) begin
                if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
                else begin
                    wexp = wb_q.pop_front();
                    chk("wb_dst_reg", {27'd0, wb_dst_reg}, {27'd0, wexp.r});
                    chk("wb_data", wb_data, wexp.d);
                end
            end
            prev_req = dmem_req;
            prev_wb  = wb_we;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_access(input logic ld, input logic st, input logic [21:0] a,
                             input logic [31:0] wd, input logic ud, input logic [4:0] dr,
                             input int ack_at, input logic [31:0] rd,
                             input int exp_stall, input int exp_req, input logic br,
                             input logic [31:0] exp_wbd);
        int  nreq, nstall;
        logic done;
        mem_q.push_back('{w: st, a: a, d: wd});
        if (ud) wb_q.push_back('{r: dr, d: exp_wbd});
        @(posedge clk); #1;
        re = ld; we = st; addr = a; wdata = wd; use_dst_reg = ud; dst_reg = dr;
        is_branch = br; dmem_rdata = rd; alu_result = 32'hDEAD_BEEF;
        nreq = 0; nstall = 0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (i == 0) chk("branch_blocked_by_access", {31'd0, branch_taken}, 32'd0);
            if (dmem_req) nreq++;
            if (stall) nstall++;
            dmem_ack = dmem_req && (nreq == ack_at);
            if (!stall) done = 1'b1;
        end
        chk("access_completes", {31'd0, done}, 32'd1);
        chk("stall_cycles", 32'(nstall), 32'(exp_stall));
        chk("req_cycles", 32'(nreq), 32'(exp_req));
        @(posedge clk); #1;
        dmem_ack = 1'b0; re = 1'b0; we = 1'b0; use_dst_reg = 1'b0; is_branch = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] ev;
        logic       done;
        int         n;
        rst_n = 1'b0; hlt = 1'b0; re = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        alu_result = '0; use_dst_reg = 1'b0; dst_reg = '0; is_branch = 1'b1;
        branch_cond = 3'b111; flag_ov = 1'b0; flag_neg = 1'b0; flag_zero = 1'b0;
        pc_target = 22'h1234; dmem_rdata = '0; dmem_ack = 1'b0;
        #12;
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
        chk("rst_dmem_addr", {10'd0, dmem_addr}, 32'd0);
        re = 1'b0; is_branch = 1'b0;
        #1 rst_n = 1'b1;

        // ALU writeback, then load with ack in the 3rd WAIT cycle
        @(posedge clk); #1;
        use_dst_reg = 1'b1; dst_reg = 5'd3; alu_result = 32'hA5A5_0003;
        wb_q.push_back('{r: 5'd3, d: 32'hA5A5_0003});
        @(posedge clk); #1;
        use_dst_reg = 1'b0;
        idle(1);
        do_access(1'b1, 1'b0, 22'h00010, 32'h0, 1'b1, 5'd5, 3, 32'hCAFE_0001, 4, 3, 1'b0, 32'hCAFE_0001);
        idle(1);

        // Store, then re&we (store wins, load buffer written back) with a branch pending
        do_access(1'b0, 1'b1, 22'h3FFFFF, 32'h1234_5678, 1'b0, 5'd6, 1, 32'h0, 2, 1, 1'b0, 32'h0);
        @(negedge clk);
        chk("store_no_wb_we", {31'd0, wb_we}, 32'd0);
        branch_cond = 3'b111;
        do_access(1'b1, 1'b1, 22'h000ABC, 32'h5555_AAAA, 1'b1, 5'd7, 1, 32'h0BAD_F00D, 2, 1, 1'b1, 32'h0BAD_F00D);
        idle(1);

        // Branch table: set 0 Z=1,N=0,V=0; set 1 Z=0,N=1,V=1; set 2 all clear
        for (int s = 0; s < 3; s++) begin
            case (s)
                0:       begin flag_zero = 1'b1; flag_neg = 1'b0; flag_ov = 1'b0; ev = 8'b1011_0010; end
                1:       begin flag_zero = 1'b0; flag_neg = 1'b1; flag_ov = 1'b1; ev = 8'b1110_1001; end
                default: begin flag_zero = 1'b0; flag_neg = 1'b0; flag_ov = 1'b0; ev = 8'b1001_0101; end
            endcase
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                is_branch = 1'b1; branch_cond = 3'(c); pc_target = 22'h100 + 22'(s * 8 + c);
                @(negedge clk);
                chk($sformatf("branch_taken_s%0d_c%0d", s, c), {31'd0, branch_taken}, {31'd0, ev[c]});
                chk("branch_pc", {10'd0, branch_pc}, {10'd0, 22'h100 + 22'(s * 8 + c)});
                chk("branch_no_stall", {31'd0, stall}, 32'd0);
            end
        end
        @(posedge clk); #1;
        hlt = 1'b1; branch_cond = 3'b111;
        @(negedge clk);
        chk("branch_hlt", {31'd0, branch_taken}, 32'd0);
        @(posedge clk); #1;
        hlt = 1'b0; is_branch = 1'b0;

        // Timeout: no ack, request drops after 4 WAIT cycles
        chk("mem_err_before_timeout", {31'd0, mem_err}, 32'd0);
        do_access(1'b1, 1'b0, 22'h00002A, 32'h0, 1'b1, 5'd9, 0, 32'h0, 5, 4, 1'b0, 32'h0);
        chk("mem_err_set", {31'd0, mem_err}, 32'd1);
        idle(3);
        chk("mem_err_sticky", {31'd0, mem_err}, 32'd1);

        // hlt raised in WAIT: access completes, WB waits for hlt to drop
        @(posedge clk); #1;
        re = 1'b1; addr = 22'h000055; wdata = 32'h0; use_dst_reg = 1'b1; dst_reg = 5'd11;
        dmem_rdata = 32'h600D_0011;
        mem_q.push_back('{w: 1'b0, a: 22'h000055, d: 32'h0});
        wb_q.push_back('{r: 5'd11, d: 32'h600D_0011});
        @(posedge clk); #1;
        hlt = 1'b1;
        n = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (dmem_req) n++;
            dmem_ack = dmem_req && (n == 2);
            if (!stall) done = 1'b1;
        end
        chk("hlt_access_completes", {31'd0, done}, 32'd1);
        chk("hlt_req_cycles", 32'(n), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hlt_wb_hold", {31'd0, wb_we}, 32'd0);
            chk("hlt_req_low", {31'd0, dmem_req}, 32'd0);
        end
        @(posedge clk); #1;
        hlt = 1'b0;
        @(posedge clk); #1;
        re = 1'b0; use_dst_reg = 1'b0;
        idle(1);
        @(posedge clk); #1;
        hlt = 1'b1; re = 1'b1; addr = 22'h000066;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hlt_blocks_stall", {31'd0, stall}, 32'd0);
            chk("hlt_blocks_req", {31'd0, dmem_req}, 32'd0);
        end
        @(posedge clk); #1;
        re = 1'b0; hlt = 1'b0;
        idle(1);

        // Reset during WAIT
        @(posedge clk); #1;
        use_dst_reg = 1'b1; dst_reg = 5'd2; alu_result = 32'h1111_2222;
        wb_q.push_back('{r: 5'd2, d: 32'h1111_2222});
        @(posedge clk); #1;
        use_dst_reg = 1'b0; re = 1'b1; addr = 22'h000077;
        mem_q.push_back('{w: 1'b0, a: 22'h000077, d: 32'h0});
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        chk("pre_rst_wb_we", {31'd0, wb_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("async_rst_stall", {31'd0, stall}, 32'd0);
        chk("async_rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("async_rst_mem_err", {31'd0, mem_err}, 32'd0);
        re = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_idle_req", {31'd0, dmem_req}, 32'd0);
        do_access(1'b1, 1'b0, 22'h000088, 32'h0, 1'b1, 5'd4, 1, 32'hFEED_0088, 2, 1, 1'b0, 32'hFEED_0088);
        idle(3);

        chk("mem_q_drained", 32'(mem_q.size()), 32'd0);
        chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
